// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder (OV7670 control port model).
package sccb_pkg;

    localparam logic [6:0] CAM_ADDR    = 7'h21;
    localparam int         SCCB_BYTE_W = 8;
    localparam logic       ACK         = 1'b0;
    localparam logic       NACK        = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DEV_ID,
        SUB_ADDR,
        WDATA,
        RDATA,
        RACK,
        IGNORE
    } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// SCL/SDA synchronizers, edge detection and START/STOP decoding.
// All flags are registered, so they appear 3 clocks after the pin change.
module sccb_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_sda_s,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_d_q;
    logic       sda_d_q;
    logic       scl_rise_q;
    logic       scl_fall_q;
    logic       start_q;
    logic       stop_q;

    // Sync flops reset to the idle-bus level so reset release creates no edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i_scl};
            sda_sync_q <= {sda_sync_q[0], i_sda};
            scl_d_q    <= scl_sync_q[1];
            sda_d_q    <= sda_sync_q[1];
            scl_rise_q <= scl_sync_q[1] & ~scl_d_q;
            scl_fall_q <= ~scl_sync_q[1] & scl_d_q;
            start_q    <= scl_sync_q[1] & scl_d_q & sda_d_q & ~sda_sync_q[1];
            stop_q     <= scl_sync_q[1] & scl_d_q & ~sda_d_q & sda_sync_q[1];
        end
    end

    // sda_d_q holds the SDA level from the same cycle the SCL edge was seen.
    assign o_scl_rise  = scl_rise_q;
    assign o_scl_fall  = scl_fall_q;
    assign o_sda_s     = sda_d_q;
    assign o_start_det = start_q;
    assign o_stop_det  = stop_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: device-ID match, 3-phase writes and 2-phase reads against
// an external single-port register interface. SDA is open-drain (0 or Z).
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CAM_ADDR,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic       o_start,
    output logic       o_stop,
    output logic [2:0] o_state
);

    logic scl_rise;
    logic scl_fall;
    logic sda_s;
    logic start_det;
    logic stop_det;

    sccb_line_sync u_line_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_scl       (i_scl),
        .i_sda       (io_sda),
        .o_scl_rise  (scl_rise),
        .o_scl_fall  (scl_fall),
        .o_sda_s     (sda_s),
        .o_start_det (start_det),
        .o_stop_det  (stop_det)
    );

    sccb_state_e            state_q;
    logic [3:0]             bit_cnt_q;
    logic [SCCB_BYTE_W-1:0] shift_q;
    logic [SCCB_BYTE_W-1:0] tx_q;
    logic [7:0]             ptr_q;
    logic [7:0]             wdata_q;
    logic                   we_q;
    logic                   busy_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   sda_oe_q;

    logic [7:0] byte_in;
    logic [7:0] ptr_inc;

    assign byte_in = {shift_q[6:0], sda_s};
    assign ptr_inc = {7'd0, AUTO_INC};

    // bit_cnt_q counts SCL rises in a byte: 0..7 data, 8 = ACK slot driven, 9 = ACK clocked.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            if (we_q) ptr_q <= ptr_q + ptr_inc;

            if (stop_det) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                stop_q    <= 1'b1;
            end else if (start_det) begin
                state_q   <= DEV_ID;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                start_q   <= 1'b1;
            end else begin
                case (state_q)
                    DEV_ID, SUB_ADDR, WDATA: begin
                        if (scl_rise && bit_cnt_q != 4'd9) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q < 4'd8) shift_q <= byte_in;
                            if (bit_cnt_q == 4'd7) begin
                                if (state_q == DEV_ID && byte_in[7:1] != DEV_ADDR) begin
                                    state_q <= IGNORE;
                                end else if (state_q == DEV_ID) begin
                                    busy_q <= 1'b1;
                                end else if (state_q == SUB_ADDR) begin
                                    ptr_q <= byte_in;
                                end else begin
                                    wdata_q <= byte_in;
                                    we_q    <= 1'b1;
                                end
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q <= 1'b1;
                            end else if (bit_cnt_q == 4'd9) begin
                                bit_cnt_q <= '0;
                                sda_oe_q  <= 1'b0;
                                // shift_q[0] is the R/W bit of the ID byte.
                                if (state_q == DEV_ID && shift_q[0]) begin
                                    state_q  <= RDATA;
                                    tx_q     <= i_reg_rdata;
                                    sda_oe_q <= ~i_reg_rdata[7];
                                end else if (state_q == DEV_ID) begin
                                    state_q <= SUB_ADDR;
                                end else begin
                                    state_q <= WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise && bit_cnt_q < 4'd8) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= RACK;
                        end else if (scl_fall && bit_cnt_q != 4'd0) begin
                            sda_oe_q <= ~tx_q[6];
                            tx_q     <= {tx_q[6:0], 1'b0};
                        end
                    end
                    RACK: begin
                        if (scl_rise && bit_cnt_q == 4'd0) begin
                            if (sda_s == ACK) begin
                                ptr_q     <= ptr_q + ptr_inc;
                                bit_cnt_q <= 4'd1;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd1) begin
                            tx_q      <= i_reg_rdata;
                            sda_oe_q  <= ~i_reg_rdata[7];
                            bit_cnt_q <= '0;
                            state_q   <= RDATA;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign io_sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign o_reg_addr  = ptr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_we    = we_q;
    assign o_busy      = busy_q;
    assign o_start     = start_q;
    assign o_stop      = stop_q;
    assign o_state     = state_q;

endmodule
